// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and the ID/EX control record
package pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RA_W  = 5;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_RSV = 3'b111;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       illegal;
        logic       use_imm;
        logic [2:0] op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, illegal: 1'b0,
                                      use_imm: 1'b0, op: ALU_MOV};

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - picks the forwarding source for one source register
// data is only meaningful when sel != FWD_NONE; the caller supplies the stored value otherwise.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W
) (
    input  logic [RA_W-1:0]  src,
    input  logic             exmem_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       sel
);

    logic src_nz;

    assign src_nz = |src;

    always_comb begin
        data = '0;
        sel  = FWD_NONE;
        if (exmem_reg_write && (exmem_rd == src) && src_nz) begin
            data = exmem_result;
            sel  = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd == src) && src_nz) begin
            data = memwb_result;
            sel  = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX stage register with operand forwarding into the ALU
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [IMM_W-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic [2:0]       id_alu_op,
    input  logic             id_reg_write,
    input  logic             exmem_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] alu_r2,
    output logic [WIDTH-1:0] alu_r3,
    output logic [2:0]       alu_op,
    output logic             ex_valid,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_illegal
);

    ctrl_t            ctrl_q;
    logic [RA_W-1:0]  rs_q, rt_q, rd_q;
    logic [WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
    logic [WIDTH-1:0] imm_ext, fwd_a, fwd_b, opnd_b;
    logic [1:0]       sel_a, sel_b;
    logic             id_illegal, refresh_rs, refresh_rt;

    assign imm_ext    = {{(WIDTH-IMM_W){id_imm[IMM_W-1]}}, id_imm};
    assign id_illegal = (id_alu_op == ALU_RSV);

    // A held operand whose producer retires from MEM/WB must pick up that value now.
    assign refresh_rs = memwb_reg_write && (memwb_rd == rs_q) && (rs_q != '0);
    assign refresh_rt = memwb_reg_write && (memwb_rd == rt_q) && (rt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (flush) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (stall) begin
            if (refresh_rs) begin
                rs_data_q <= memwb_result;
            end
            if (refresh_rt) begin
                rt_data_q <= memwb_result;
            end
        end else begin
            ctrl_q.valid     <= id_valid;
            ctrl_q.reg_write <= id_reg_write && id_valid && !id_illegal;
            ctrl_q.illegal   <= id_illegal;
            ctrl_q.use_imm   <= id_use_imm;
            ctrl_q.op        <= id_illegal ? ALU_MOV : id_alu_op;
            rs_q             <= id_rs;
            rt_q             <= id_rt;
            rd_q             <= id_rd;
            rs_data_q        <= id_rs_data;
            rt_data_q        <= id_rt_data;
            imm_q            <= imm_ext;
        end
    end

    fwd_sel #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_a (
        .src             (rs_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .data            (fwd_a),
        .sel             (sel_a)
    );

    fwd_sel #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_b (
        .src             (rt_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .data            (fwd_b),
        .sel             (sel_b)
    );

    assign alu_r2       = (sel_a == FWD_NONE) ? rs_data_q : fwd_a;
    assign opnd_b       = (sel_b == FWD_NONE) ? rt_data_q : fwd_b;
    assign alu_r3       = ctrl_q.use_imm ? imm_q : opnd_b;
    assign alu_op       = ctrl_q.op;
    assign ex_valid     = ctrl_q.valid;
    assign ex_rd        = rd_q;
    assign ex_reg_write = ctrl_q.reg_write && ctrl_q.valid;
    assign ex_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - vector table and scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    typedef struct {
        logic        stall, flush, valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data;
        logic [15:0] imm;
        logic        use_imm;
        logic [2:0]  op;
        logic        regw;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
    } stim_t;

    typedef struct {
        logic [31:0] r2, r3;
        logic [2:0]  op;
        logic        valid;
        logic [4:0]  rd;
        logic        regw, ill;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
        string name;
    } vec_t;

    logic        clk, rst_n, stall, flush, id_valid, id_use_imm, id_reg_write;
    logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd, ex_rd;
    logic [31:0] id_rs_data, id_rt_data, exmem_result, memwb_result, alu_r2, alu_r3;
    logic [15:0] id_imm;
    logic [2:0]  id_alu_op, alu_op;
    logic        exmem_reg_write, memwb_reg_write, ex_valid, ex_reg_write, ex_illegal;

    int    n_vec = 0;
    int    n_bad = 0;
    exp_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    id_ex_stage #(.WIDTH(32), .RA_W(5), .IMM_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_alu_op       (id_alu_op),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .alu_r2          (alu_r2),
        .alu_r3          (alu_r3),
        .alu_op          (alu_op),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_illegal      (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic st, input logic fl, input logic vl,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] rsd, input logic [31:0] rtd,
                                 input logic [15:0] imm, input logic ui,
                                 input logic [2:0] op, input logic rw);
        stim_t s;
        s.stall = st;  s.flush = fl;  s.valid = vl;
        s.rs = rs;     s.rt = rt;     s.rd = rd;
        s.rs_data = rsd; s.rt_data = rtd;
        s.imm = imm;   s.use_imm = ui; s.op = op; s.regw = rw;
        s.exw = 1'b0;  s.exrd = '0;   s.exres = '0;
        s.mww = 1'b0;  s.mwrd = '0;   s.mwres = '0;
        return s;
    endfunction

    function automatic stim_t fw(input stim_t s_in, input logic exw, input logic [4:0] exrd,
                                 input logic [31:0] exres, input logic mww,
                                 input logic [4:0] mwrd, input logic [31:0] mwres);
        stim_t s;
        s = s_in;
        s.exw = exw; s.exrd = exrd; s.exres = exres;
        s.mww = mww; s.mwrd = mwrd; s.mwres = mwres;
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] r2, input logic [31:0] r3, input logic [2:0] op,
                                input logic vl, input logic [4:0] rd, input logic rw, input logic il);
        exp_t e;
        e.r2 = r2; e.r3 = r3; e.op = op; e.valid = vl; e.rd = rd; e.regw = rw; e.ill = il;
        return e;
    endfunction

    function automatic vec_t vec(input stim_t s, input exp_t e, input string name);
        vec_t v;
        v.s = s; v.e = e; v.name = name;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        stall = s.stall; flush = s.flush; id_valid = s.valid;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_rs_data = s.rs_data; id_rt_data = s.rt_data;
        id_imm = s.imm; id_use_imm = s.use_imm; id_alu_op = s.op; id_reg_write = s.regw;
        exmem_reg_write = s.exw; exmem_rd = s.exrd; exmem_result = s.exres;
        memwb_reg_write = s.mww; memwb_rd = s.mwrd; memwb_result = s.mwres;
    endtask

    task automatic check_out();
        exp_t  e;
        string nm;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: output seen with no expectation queued");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (alu_r2 !== e.r2 || alu_r3 !== e.r3 || alu_op !== e.op || ex_valid !== e.valid ||
                ex_rd !== e.rd || ex_reg_write !== e.regw || ex_illegal !== e.ill) begin
                n_bad++;
                $display("FAIL %s: got r2=%h r3=%h op=%0d v=%b rd=%0d rw=%b ill=%b, want r2=%h r3=%h op=%0d v=%b rd=%0d rw=%b ill=%b",
                         nm, alu_r2, alu_r3, alu_op, ex_valid, ex_rd, ex_reg_write, ex_illegal,
                         e.r2, e.r3, e.op, e.valid, e.rd, e.regw, e.ill);
            end
        end
    endtask

    task automatic step(input vec_t v);
        drive(v.s);
        exp_q.push_back(v.e);
        name_q.push_back(v.name);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic expect_now(input exp_t e, input string name);
        exp_q.push_back(e);
        name_q.push_back(name);
        check_out();
    endtask

    initial begin
        exp_t  bubble;
        stim_t junk;
        bubble = ex(32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_rs_data = '0; id_rt_data = '0;
        id_imm = '0; id_use_imm = 1'b0; id_alu_op = '0; id_reg_write = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
        #12;
        expect_now(bubble, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(vec(mk(0,0,1, 1,2,4, 5,7, 16'h0,0, 3'd2,1),
                          ex(5,7, 3'd2,1,4,1,0), "add_basic"));
        tbl.push_back(vec(fw(mk(0,0,1, 1,2,4, 5,7, 16'h0,0, 3'd2,1), 1,1,32'h10, 1,1,32'h20),
                          ex(32'h10,7, 3'd2,1,4,1,0), "fwd_exmem_prio"));
        tbl.push_back(vec(fw(mk(0,0,1, 1,2,4, 5,7, 16'h0,0, 3'd2,1), 0,1,32'h10, 1,1,32'h20),
                          ex(32'h20,7, 3'd2,1,4,1,0), "fwd_memwb"));
        tbl.push_back(vec(fw(mk(0,0,1, 0,0,3, 32'hAB,32'hCD, 16'h0,0, 3'd2,1), 1,0,32'h10, 1,0,32'h20),
                          ex(32'hAB,32'hCD, 3'd2,1,3,1,0), "no_fwd_r0"));
        tbl.push_back(vec(fw(mk(0,0,1, 1,2,5, 3,7, 16'hFFFE,1, 3'd4,1), 1,2,32'h99, 0,0,0),
                          ex(3,32'hFFFFFFFE, 3'd4,1,5,1,0), "imm_neg"));
        tbl.push_back(vec(mk(0,0,1, 1,2,5, 3,7, 16'h7FFF,1, 3'd3,1),
                          ex(3,32'h00007FFF, 3'd3,1,5,1,0), "imm_pos"));
        tbl.push_back(vec(fw(mk(0,0,1, 5,6,8, 2,1, 16'h0,0, 3'd2,1), 1,5,32'h66, 1,6,32'h77),
                          ex(32'h66,32'h77, 3'd2,1,8,1,0), "fwd_split"));
        tbl.push_back(vec(fw(mk(0,0,1, 5,6,8, 2,1, 16'h0,0, 3'd2,1), 1,6,32'h66, 1,6,32'h77),
                          ex(2,32'h66, 3'd2,1,8,1,0), "fwd_rt_prio"));
        tbl.push_back(vec(mk(0,0,0, 1,2,7, 5,7, 16'h0,0, 3'd5,1),
                          ex(5,7, 3'd5,0,7,0,0), "invalid_in"));
        tbl.push_back(vec(mk(0,0,1, 1,2,9, 5,7, 16'h0,0, 3'd7,1),
                          ex(5,7, 3'd0,1,9,0,1), "illegal_op"));
        tbl.push_back(vec(mk(0,0,1, 1,2,10, 5,7, 16'h0,0, 3'd6,1),
                          ex(5,7, 3'd6,1,10,1,0), "load_slt"));
        tbl.push_back(vec(mk(1,1,1, 3,4,11, 8,9, 16'h0,0, 3'd2,1),
                          bubble, "stall_and_flush"));
        tbl.push_back(vec(mk(0,0,1, 3,4,12, 8,9, 16'h0,0, 3'd0,1),
                          ex(8,9, 3'd0,1,12,1,0), "load_mov"));
        tbl.push_back(vec(mk(1,0,1, 1,2,13, 5,7, 16'hFFFF,1, 3'd3,0),
                          ex(8,9, 3'd0,1,12,1,0), "stall_hold"));
        tbl.push_back(vec(mk(0,1,1, 1,2,13, 5,7, 16'h0,0, 3'd3,1),
                          bubble, "flush"));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Multi-cycle stall on rt=3 with a MEM/WB write landing mid-stall.
        junk = mk(1,0,1, 7,7,7, 32'hDEAD,32'hDEAD, 16'h1234,1, 3'd5,0);
        step(vec(mk(0,0,1, 1,3,14, 4,1, 16'h0,0, 3'd2,1), ex(4,1, 3'd2,1,14,1,0), "stall_load"));
        step(vec(junk, ex(4,1, 3'd2,1,14,1,0), "stall_c1"));
        step(vec(fw(junk, 0,0,0, 1,3,9), ex(4,9, 3'd2,1,14,1,0), "stall_c2_refresh"));
        step(vec(fw(junk, 1,3,32'h55, 0,0,0), ex(4,32'h55, 3'd2,1,14,1,0), "stall_c3_exfwd"));
        step(vec(junk, ex(4,9, 3'd2,1,14,1,0), "stall_c4_kept"));
        step(vec(mk(0,0,0, 0,0,0, 0,0, 16'h0,0, 3'd0,0), bubble, "stall_release"));

        // Register 0 held under stall is never refreshed.
        step(vec(mk(0,0,1, 0,0,2, 5,6, 16'h0,0, 3'd2,1), ex(5,6, 3'd2,1,2,1,0), "r0_load"));
        step(vec(fw(junk, 0,0,0, 1,0,32'hEE), ex(5,6, 3'd2,1,2,1,0), "r0_stall_mw"));
        step(vec(junk, ex(5,6, 3'd2,1,2,1,0), "r0_no_refresh"));

        // Asynchronous reset mid-cycle, held through a stall+flush edge.
        step(vec(mk(0,0,1, 1,2,15, 5,7, 16'h0,0, 3'd2,1), ex(5,7, 3'd2,1,15,1,0), "pre_async"));
        #2;
        rst_n = 1'b0;
        #1;
        expect_now(bubble, "async_reset");
        drive(mk(1,1,1, 1,2,16, 5,7, 16'h0,0, 3'd2,1));
        @(posedge clk);
        #1;
        expect_now(bubble, "reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step(vec(mk(0,0,0, 0,0,0, 0,0, 16'h0,0, 3'd0,0), bubble, "post_reset_empty"));

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage that directly feeds the EX-stage `nbit_ALU`. It captures decoded instruction fields from ID once per cycle. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operand and opcode inputs. It supports stall (hold) and flush (bubble) from the hazard/branch logic.

## Interface
Parameters:
- `WIDTH`, 32, datapath width
- `RA_W`, 5, register-address width
- `IMM_W`, 16, immediate width before sign extension

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold the stage register
- `flush`  in  1  insert a bubble
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  RA_W  source/dest register numbers
- `id_rs_data`, `id_rt_data`  in  WIDTH  register-file read data
- `id_imm`  in  IMM_W  raw immediate
- `id_use_imm`  in  1  operand B = sign-extended immediate
- `id_alu_op`  in  3  ALUOp: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110 SLT, 111 reserved
- `id_reg_write`  in  1  instruction writes `rd`
- `exmem_reg_write`  in  1  EX/MEM write enable
- `exmem_rd`  in  RA_W  EX/MEM destination
- `exmem_result`  in  WIDTH  EX/MEM result
- `memwb_reg_write`  in  1  MEM/WB write enable
- `memwb_rd`  in  RA_W  MEM/WB destination
- `memwb_result`  in  WIDTH  MEM/WB result
- `alu_r2`  out  WIDTH  ALU operand R2
- `alu_r3`  out  WIDTH  ALU operand R3
- `alu_op`  out  3  ALUOp to the ALU
- `ex_valid`  out  1  EX holds a real instruction
- `ex_rd`  out  RA_W  destination, passed downstream
- `ex_reg_write`  out  1  gated write enable
- `ex_illegal`  out  1  registered flag: captured op was 111

## Operation
- Capture rule, priority `flush` > `stall` > load:
  - **Flush:** load a bubble. `valid`, `reg_write`, `illegal` = 0; op = 000; rs/rt/rd = 0; data and imm = 0.
  - **Stall:** hold all fields, except as given under Refresh.
  - **Otherwise:** load all `id_*` fields.
- Bubble on invalid input: if `id_valid`=0 on load, `reg_write` is stored as 0.
- Illegal op: op 111 is stored as 000, with `ex_illegal`=1 and `reg_write` forced to 0. `ex_valid` stays as captured.
- Immediate: sign-extended IMM_W→WIDTH at capture.
- Forwarding is combinational on the registered fields. For operand A (rs), and likewise for rt:
  - If `exmem_reg_write` && `exmem_rd`==rs && rs≠0, use `exmem_result`.
  - Else if `memwb_reg_write` && `memwb_rd`==rs && rs≠0, use `memwb_result`.
  - Else use the stored data.
  - EX/MEM has priority when both match.
- Refresh: while `stall`=1 and `flush`=0, if MEM/WB writes to a held rs or rt (≠0), that stored data register is overwritten with `memwb_result`. This prevents stale data once the producer retires.
- Output mapping:
  - `alu_r2` = forwarded A.
  - `alu_r3` = `use_imm` ? imm : forwarded B.
  - `ex_reg_write` = stored `reg_write` && `ex_valid`.
- Register 0 is never forwarded, and its stored data is never refreshed.

## Timing
- Reset (async assert, sync release): all stored fields 0. Resulting outputs:
  - `ex_valid`, `ex_reg_write`, `ex_illegal` = 0
  - `alu_op` = 000
  - `alu_r2`, `alu_r3` = 0, unless a forward source matches (none can, since rs = rt = 0)
- Latency:
  - ID→EX: 1 cycle.
  - Forward inputs → `alu_r2`/`alu_r3`: combinational, same cycle.
- Reset mid-stall or mid-flush: reset wins; the stage is empty on the first edge after release.
- Stall and flush asserted together: flush.
- Back-to-back stalls of any length are allowed. The held instruction is released unchanged on the first non-stall edge, apart from refreshed data.

## Structure
- Shared package `pipe_pkg`:
  - ALUOp localparams (`ALU_MOV` … `ALU_SLT`, `ALU_RSV`)
  - `WIDTH`/`RA_W` defaults
  - bubble constant for the stage record
- Sub-module `fwd_sel`: one instance per operand. Inputs are the source register plus the EX/MEM and MEM/WB triples; outputs are the selected data and a 2-bit select code.
- Stage register, refresh logic and immediate mux live in `id_ex_stage`.

## Test plan
- Reset → `ex_valid`=0, `alu_op`=000, `ex_reg_write`=0. Load ADD, rs=1 (5), rt=2 (7), no matching forwards → next cycle `alu_r2`=5, `alu_r3`=7, `alu_op`=010.
- EX/MEM rd=1 result 0x10 and MEM/WB rd=1 result 0x20 both writing → `alu_r2`=0x10. Drop EX/MEM → `alu_r2`=0x20. With rs=0 and both rd=0 → `alu_r2`=stored 0.
- `id_use_imm`=1, `id_imm`=0xFFFE, WIDTH=32 → `alu_r3`=0xFFFFFFFE, independent of rt forwarding.
- Stall 3 cycles holding rt=3 (data 1); MEM/WB writes r3=9 in cycle 2 and then deasserts → `alu_r3`=9 in cycles 2-3 and after release.
- Stall and flush together → next cycle `ex_valid`=0, `ex_reg_write`=0, `alu_op`=000. `id_alu_op`=111 with `id_reg_write`=1 → `ex_illegal`=1, `ex_reg_write`=0, `alu_op`=000.
- Assert `rst_n`=0 asynchronously mid-cycle while valid → outputs clear before the next edge.
